// File: rtl/pic_pkg.sv
// Shared constants for the interrupt request bank: trigger-mode encoding
// and the default channel count.
package pic_pkg;

  localparam logic TRIG_EDGE  = 1'b0;
  localparam logic TRIG_LEVEL = 1'b1;

  localparam int NUM_CH_DEF = 8;

endpackage

// File: rtl/irr_prio_enc.sv
// Lowest-index priority encoder: idx is the lowest set bit of req, 0 when
// nothing is set. valid flags that at least one bit is set.
module irr_prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/irr_bank.sv
// Interrupt request register bank with per-channel edge/level triggering,
// acknowledge, masking and lowest-index request selection.
// Optional macro IRR_BANK_SYNC_EN inserts a 2-flop synchronizer on every
// ir_in bit; without it ir_in must already be synchronous to clk.
module irr_bank
  import pic_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ir_in,
  input  logic [NUM_CH-1:0] trig_level,
  input  logic [NUM_CH-1:0] mask,
  input  logic              init_clr,
  input  logic              ack_valid,
  input  logic [IDX_W-1:0]  ack_idx,
  output logic [NUM_CH-1:0] irr,
  output logic              irq_any,
  output logic [IDX_W-1:0]  req_idx
);

  logic [NUM_CH-1:0] cond;
  logic [NUM_CH-1:0] hist;
  logic [NUM_CH-1:0] blk;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] mode_chg;
  logic [NUM_CH-1:0] ack_hit;
  logic [NUM_CH-1:0] irr_nxt;

`ifdef IRR_BANK_SYNC_EN
  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;

  // Two-stage synchronizer for asynchronous request lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ir_in;
      sync2 <= sync1;
    end
  end

  assign cond = sync2;
`else
  assign cond = ir_in;
`endif

  // Edge history, post-clear blocking and previous trigger mode.
  // blk keeps an input that was already high at init_clr from counting as a
  // new edge; a bit is released once its input is seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      blk    <= '0;
      trig_q <= '0;
    end else begin
      trig_q <= trig_level;
      if (init_clr) begin
        hist <= '0;
        blk  <= '1;
      end else begin
        hist <= cond;
        blk  <= blk & cond;
      end
    end
  end

  assign rise     = cond & ~hist & ~blk;
  assign mode_chg = trig_level ^ trig_q;

  // Decode the acknowledge; indices beyond NUM_CH-1 match no channel.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_hit[i] = ack_valid && (ack_idx == IDX_W'(i));
    end
  end

  // Per-channel next value: mode change clears, level follows input,
  // edge latches and a fresh edge beats a coincident ack.
  always_comb begin
    irr_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode_chg[i])
        irr_nxt[i] = 1'b0;
      else if (trig_level[i] == TRIG_LEVEL)
        irr_nxt[i] = cond[i] & ~ack_hit[i];
      else
        irr_nxt[i] = rise[i] | (irr[i] & ~ack_hit[i]);
    end
  end

  // Request register; init_clr overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irr <= '0;
    else if (init_clr)
      irr <= '0;
    else
      irr <= irr_nxt;
  end

  irr_prio_enc #(
    .N(NUM_CH),
    .W(IDX_W)
  ) u_prio (
    .req  (irr & ~mask),
    .idx  (req_idx),
    .valid(irq_any)
  );

endmodule

// File: tb/tb_irr_bank.sv
module tb_irr_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ir_in, trig_level, mask;
  logic        init_clr, ack_valid;
  logic [2:0]  ack_idx;
  logic [7:0]  irr;
  logic        irq_any;
  logic [2:0]  req_idx;

  logic [15:0] ir16, trig16, mask16;
  logic        clr16, ackv16;
  logic [3:0]  acki16;
  logic [15:0] irr16;
  logic        any16;
  logic [3:0]  ridx16;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  irr_bank #(.NUM_CH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .trig_level(trig_level),
    .mask(mask), .init_clr(init_clr), .ack_valid(ack_valid), .ack_idx(ack_idx),
    .irr(irr), .irq_any(irq_any), .req_idx(req_idx)
  );

  irr_bank #(.NUM_CH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .ir_in(ir16), .trig_level(trig16),
    .mask(mask16), .init_clr(clr16), .ack_valid(ackv16), .ack_idx(acki16),
    .irr(irr16), .irq_any(any16), .req_idx(ridx16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ir_in = 8'h04; trig_level = 8'h20; mask = 8'h00;
    init_clr = 1'b0; ack_valid = 1'b0; ack_idx = '0;
    ir16 = '0; trig16 = '0; mask16 = '0; clr16 = 1'b0; ackv16 = 1'b0; acki16 = '0;
    step(); step();
    chk("rst_irr", irr, 8'h00);
    chk("rst_any", irq_any, 1'b0);
    chk("rst_idx", req_idx, 3'd0);

    // Input high at reset release counts as a rising edge.
    rst_n = 1'b1;
    step();
    chk("rel_edge", irr, 8'h04);
    ir_in = 8'h00;
    ack_valid = 1'b1; ack_idx = 3'd2;
    step();
    ack_valid = 1'b0;
    chk("rel_ack", irr, 8'h00);

    // Edge channel 3.
    ir_in = 8'h08;
    step();
    chk("edge_set", irr, 8'h08);
    ir_in = 8'h00;
    step();
    chk("edge_hold", irr, 8'h08);
    chk("edge_idx", req_idx, 3'd3);
    chk("edge_any", irq_any, 1'b1);
    ack_valid = 1'b1; ack_idx = 3'd3;
    step();
    ack_valid = 1'b0;
    chk("edge_ack", irr, 8'h00);
    chk("edge_ack_any", irq_any, 1'b0);

    // Level channel 5.
    ir_in = 8'h20;
    step();
    chk("lvl_set", irr, 8'h20);
    ack_valid = 1'b1; ack_idx = 3'd5;
    step();
    ack_valid = 1'b0;
    chk("lvl_ack_low", irr, 8'h00);
    step();
    chk("lvl_reset", irr, 8'h20);
    ir_in = 8'h00;
    step();
    chk("lvl_drop", irr, 8'h00);

    // Mask and priority.
    ir_in = 8'h12;
    step();
    ir_in = 8'h00;
    step();
    chk("pri_irr", irr, 8'h12);
    chk("pri_idx_nomask", req_idx, 3'd1);
    mask = 8'h02; #1;
    chk("pri_any", irq_any, 1'b1);
    chk("pri_idx", req_idx, 3'd4);
    mask = 8'h12; #1;
    chk("mask_any", irq_any, 1'b0);
    chk("mask_idx", req_idx, 3'd0);
    chk("mask_irr", irr, 8'h12);
    mask = 8'h00;

    // Collision: new edge with ack of the same channel.
    ir_in = 8'h01;
    step();
    chk("col_set", irr, 8'h13);
    ir_in = 8'h00;
    step();
    ir_in = 8'h01; ack_valid = 1'b1; ack_idx = 3'd0;
    step();
    chk("col_set_wins", irr, 8'h13);
    ir_in = 8'h00; ack_valid = 1'b0;
    step();
    ir_in = 8'h01; ack_valid = 1'b1; ack_idx = 3'd0; init_clr = 1'b1;
    step();
    ack_valid = 1'b0; init_clr = 1'b0;
    chk("col_clr", irr, 8'h00);
    step();
    chk("clr_block1", irr, 8'h00);
    step();
    chk("clr_block2", irr, 8'h00);
    ir_in = 8'h00;
    step();
    ir_in = 8'h01;
    step();
    chk("clr_rearm", irr, 8'h01);

    // Mode change on channel 0 clears it for the change edge.
    trig_level = 8'h21;
    step();
    chk("mode_clr", irr, 8'h00);
    step();
    chk("mode_lvl", irr, 8'h01);
    trig_level = 8'h20; ir_in = 8'h00;
    step();
    chk("mode_back", irr, 8'h00);

    // Masked channel still latches.
    mask = 8'h40; ir_in = 8'h40;
    step();
    ir_in = 8'h00;
    chk("mask_latch", irr, 8'h40);
    chk("mask_latch_any", irq_any, 1'b0);
    mask = 8'h00; #1;
    chk("unmask_idx", req_idx, 3'd6);

    // 16-channel instance.
    ir16 = 16'h9200;
    step();
    ir16 = 16'h0000;
    step();
    chk("w16_irr", irr16, 16'h9200);
    chk("w16_idx", ridx16, 4'd9);
    ackv16 = 1'b1; acki16 = 4'd15;
    step();
    ackv16 = 1'b0;
    chk("w16_ack15", irr16, 16'h1200);
    chk("w16_idx2", ridx16, 4'd9);
    ackv16 = 1'b1; acki16 = 4'd9;
    step();
    ackv16 = 1'b0;
    chk("w16_ack9", ridx16, 4'd12);

    // Asynchronous reset mid-operation.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irr", irr, 8'h00);
    chk("arst_any", irq_any, 1'b0);
    chk("arst_irr16", irr16, 16'h0000);
    chk("arst_idx16", ridx16, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
